// File: rtl/line_raster_stream.sv
// All-octant Bresenham line rasteriser: one two-endpoint command in, a
// back-pressured stream of pixels out, from (x0,y0) through (x1,y1).
module line_raster_stream #(
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [COORD_W-1:0] r_cx, r_cy, r_x1, r_y1;
    logic [COORD_W:0]   r_dx, r_dy;   // dx >= 0, dy <= 0, two's complement
    logic [COORD_W+1:0] r_err;
    logic               r_sx_pos, r_sy_pos;

    logic [COORD_W-1:0] w_adx, w_ady;
    logic [COORD_W+2:0] w_e2, w_dx_e2, w_dy_e2;
    logic [COORD_W+1:0] w_err_next;
    logic               w_last, w_hs, w_step_x, w_step_y;

    // The current position was loaded with (x0,y0) at accept time
    assign w_adx = (r_x1 > r_cx) ? r_x1 - r_cx : r_cx - r_x1;
    assign w_ady = (r_y1 > r_cy) ? r_y1 - r_cy : r_cy - r_y1;

    assign w_last   = (r_cx == r_x1) && (r_cy == r_y1);
    assign w_hs     = (r_state == S_DRAW) && pix_ready;
    assign w_e2     = {r_err, 1'b0};
    assign w_dx_e2  = {2'b00, r_dx};
    assign w_dy_e2  = {{2{r_dy[COORD_W]}}, r_dy};
    assign w_step_x = $signed(w_e2) >= $signed(w_dy_e2);
    assign w_step_y = $signed(w_e2) <= $signed(w_dx_e2);
    assign w_err_next = r_err
                      + (w_step_x ? {r_dy[COORD_W], r_dy} : {(COORD_W+2){1'b0}})
                      + (w_step_y ? {1'b0, r_dx}          : {(COORD_W+2){1'b0}});

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid)        w_state_next = S_SETUP;
            S_SETUP:                       w_state_next = S_DRAW;
            S_DRAW:  if (w_hs && w_last)   w_state_next = S_DONE;
            S_DONE:                        w_state_next = S_IDLE;
            default:                       w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cx     <= '0;
            r_cy     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_pos <= 1'b0;
            r_sy_pos <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    r_cx <= cmd_x0;
                    r_cy <= cmd_y0;
                    r_x1 <= cmd_x1;
                    r_y1 <= cmd_y1;
                end
                S_SETUP: begin
                    r_dx     <= {1'b0, w_adx};
                    r_dy     <= {(COORD_W+1){1'b0}} - {1'b0, w_ady};
                    r_err    <= {2'b00, w_adx} - {2'b00, w_ady};
                    r_sx_pos <= r_cx < r_x1;
                    r_sy_pos <= r_cy < r_y1;
                end
                S_DRAW: if (w_hs && !w_last) begin
                    r_err <= w_err_next;
                    if (w_step_x) r_cx <= r_sx_pos ? r_cx + 1'b1 : r_cx - 1'b1;
                    if (w_step_y) r_cy <= r_sy_pos ? r_cy + 1'b1 : r_cy - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign pix_valid = (r_state == S_DRAW);
    assign pix_x     = r_cx;
    assign pix_y     = r_cy;
    assign pix_last  = (r_state == S_DRAW) && w_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
endmodule

// File: tb/tb_line_raster_stream.sv
// Bench for line_raster_stream: expected pixels are queued when a command is
// issued and popped as the DUT hands each pixel over.
module tb_line_raster_stream;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic         pix_valid;
    logic         pix_ready = 1'b0;
    logic [W-1:0] pix_x, pix_y;
    logic         pix_last, busy, done;

    line_raster_stream #(.COORD_W(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x0, y0, x1, y1;
        int           n;
    } vec_t;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             acc_dones;
    logic [2*W:0]   exp_q[$];
    vec_t           vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic push_pix(input int x, input int y, input bit last);
        logic [W-1:0] bx, by;
        bx = x[W-1:0];
        by = y[W-1:0];
        exp_q.push_back({bx, by, last});
    endtask

    // Reference Bresenham walk in plain integers
    task automatic push_model(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, e2, x, y;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x   = x0;
        y   = y0;
        for (int k = 0; k < 1024; k++) begin
            push_pix(x, y, (x == x1) && (y == y1));
            if ((x == x1) && (y == y1)) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic send(input int x0, input int y0, input int x1, input int y1);
        cmd_x0 = x0[W-1:0];
        cmd_y0 = y0[W-1:0];
        cmd_x1 = x1[W-1:0];
        cmd_y1 = y1[W-1:0];
        cmd_valid = 1'b1;
    endtask

    // Runs from #1 after an edge until n_done done pulses have been seen
    task automatic drain(input int n_done, input int bp, output int n_pix);
        int           dones = 0;
        int           cyc = 0;
        bit           stall = 0, prev_last = 0, acc;
        logic [W-1:0] hx = '0, hy = '0;
        logic         hl = 1'b0;
        logic [2*W:0] e;
        n_pix = 0;
        while (dones < n_done && cyc < 3000) begin
            pix_ready = (bp == 0) ? 1'b1 : (cyc % 3 == 0);
            if (stall)
                check("stall_hold", {pix_valid, pix_x, pix_y, pix_last}, {1'b1, hx, hy, hl});
            if (prev_last)
                check("done_pulse", done, 1'b1);
            else if (done)
                check("spurious_done", done, 1'b0);
            if (done) begin
                check("done_excl", cmd_ready, 1'b0);
                dones++;
                $display("[TB] line complete: done #%0d, %0d pixels so far", dones, n_pix);
            end
            if (cmd_valid && busy)
                check("cmd_ignored", cmd_ready, 1'b0);
            acc = cmd_valid && cmd_ready;
            if (acc) acc_dones = dones;
            prev_last = 0;
            if (pix_valid && pix_ready) begin
                n_pix++;
                if (exp_q.size() == 0) begin
                    check("extra_pixel", {pix_x, pix_y, pix_last}, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", {pix_x, pix_y, pix_last}, e);
                end
                prev_last = pix_last;
            end
            stall = pix_valid && !pix_ready;
            hx = pix_x; hy = pix_y; hl = pix_last;
            @(posedge clk); #1;
            cyc++;
            if (acc) cmd_valid = 1'b0;
        end
        check("drain_timeout", dones, n_done);
    endtask

    task automatic check_idle(input string name);
        check({name, "_idle"}, {cmd_ready, busy, pix_valid, done}, 4'b1000);
        check({name, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{8'd7,   8'd7,   8'd7,   8'd7,   1};
        vecs[1] = '{8'd0,   8'd3,   8'd0,   8'd0,   4};
        vecs[2] = '{8'd255, 8'd0,   8'd0,   8'd0,   256};
        vecs[3] = '{8'd0,   8'd255, 8'd255, 8'd0,   256};
        vecs[4] = '{8'd0,   8'd0,   8'd255, 8'd255, 256};
        vecs[5] = '{8'd100, 8'd50,  8'd20,  8'd90,  81};
        vecs[6] = '{8'd3,   8'd200, 8'd250, 8'd190, 248};
        vecs[7] = '{8'd255, 8'd255, 8'd254, 8'd0,   256};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {cmd_ready, pix_valid, busy, done, pix_last}, 5'b10000);
        check("reset_xy", {pix_x, pix_y}, '0);
        rst = 1'b0;

        // First octant with explicit expected pixels and latency check
        push_pix(0, 0, 0); push_pix(1, 0, 0); push_pix(2, 1, 0);
        push_pix(3, 1, 0); push_pix(4, 2, 0); push_pix(5, 2, 1);
        send(0, 0, 5, 2);
        pix_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("setup_cycle", {pix_valid, busy, cmd_ready}, 3'b010);
        @(posedge clk); #1;
        check("first_pix_latency", pix_valid, 1'b1);
        drain(1, 0, n);
        check("oct1_count", n, 6);
        check_idle("oct1");

        // Steep, negative in both axes
        push_pix(10, 10, 0); push_pix(10, 9, 0); push_pix(9, 8, 0); push_pix(9, 7, 0);
        push_pix(9, 6, 0);   push_pix(8, 5, 0);  push_pix(8, 4, 1);
        send(10, 10, 8, 4);
        drain(1, 0, n);
        check("steep_count", n, 7);
        check_idle("steep");

        foreach (vecs[i]) begin
            push_model(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
            send(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
            drain(1, 0, n);
            check("vec_count", n, vecs[i].n);
            check_idle("vec");
        end

        // Back-pressure: ready pattern 1,0,0,1,...
        push_pix(0, 0, 0); push_pix(1, 1, 0); push_pix(2, 2, 0); push_pix(3, 3, 1);
        send(0, 0, 3, 3);
        drain(1, 1, n);
        check("bp_count", n, 4);
        check_idle("bp");

        // Reset while the third pixel of a line is presented
        send(0, 0, 20, 5);
        pix_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_third_pix", {pix_valid, pix_x, pix_y}, {1'b1, 8'd2, 8'd1});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_reset_state", {pix_valid, busy, cmd_ready, done}, 4'b0010);
        push_model(1, 1, 2, 2);
        send(1, 1, 2, 2);
        drain(1, 0, n);
        check("post_reset_count", n, 2);
        check_idle("post_reset");

        // Second command held while the first one is still drawing
        push_model(4, 9, 12, 2);
        push_model(200, 100, 190, 103);
        send(4, 9, 12, 2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc_dones = -1;
        send(200, 100, 190, 103);
        check("busy_not_ready", cmd_ready, 1'b0);
        drain(2, 0, n);
        check("b2b_count", n, 20);
        check("b2b_accept_after_done", acc_dones, 1);
        check_idle("b2b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
